// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle RV32-style datapath.
// Walks each instruction through FETCH, DECODE, EXEC, MEM and WB, and drives
// the memory handshake, datapath strobes and operand/writeback selects.
// Optional feature macro: RETIRE_CNT_EN adds a 32-bit retired-instruction
// counter output (retire_cnt); the default build has no counter.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        br_taken,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic        alu_src_imm,
    output logic        pc_src_br,
    output logic        wb_sel,
    output logic [2:0]  state,
    output logic        illegal
`ifdef RETIRE_CNT_EN
    ,
    output logic [31:0] retire_cnt
`endif
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_OPIMM,
        C_OP,
        C_ILLEGAL
    } iclass_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] ir_q;
    iclass_t     iclass;
    logic [2:0]  funct3;
    logic        ir_unused;

    assign funct3    = ir_q[14:12];
    assign state     = state_q;
    // Only opcode and funct3 steer control; the rest of the word feeds the datapath.
    assign ir_unused = ^{ir_q[31:15], ir_q[11:7]};

    // State register and instruction latch; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (ir_we) begin
                ir_q <= instr;
            end
        end
    end

    // Classify the latched instruction; reserved funct3 codes count as illegal.
    always_comb begin
        iclass = C_ILLEGAL;
        case (ir_q[6:0])
            OPC_LOAD: begin
                if (!(funct3 inside {3'b011, 3'b110, 3'b111})) begin
                    iclass = C_LOAD;
                end
            end
            OPC_STORE:  iclass = C_STORE;
            OPC_BRANCH: begin
                if (!(funct3 inside {3'b010, 3'b011})) begin
                    iclass = C_BRANCH;
                end
            end
            OPC_OPIMM:  iclass = C_OPIMM;
            OPC_OP:     iclass = C_OP;
            default:    iclass = C_ILLEGAL;
        endcase
    end

    // Next-state and output decode; while rst is high the outputs read as FETCH with no strobes.
    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        reg_we      = 1'b0;
        alu_src_imm = 1'b0;
        pc_src_br   = 1'b0;
        wb_sel      = 1'b0;
        illegal     = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                state_d = (iclass == C_ILLEGAL) ? S_TRAP : S_EXEC;
            end

            S_EXEC: begin
                alu_src_imm = (iclass == C_LOAD) || (iclass == C_STORE) || (iclass == C_OPIMM);
                case (iclass)
                    C_LOAD, C_STORE: state_d = S_MEM;
                    C_OPIMM, C_OP:   state_d = S_WB;
                    C_BRANCH: begin
                        pc_we     = 1'b1;
                        pc_src_br = br_taken;
                        state_d   = S_FETCH;
                    end
                    default:         state_d = S_TRAP;
                endcase
            end

            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (iclass == C_STORE);
                if (mem_ready) begin
                    if (iclass == C_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end

            S_WB: begin
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                wb_sel  = (iclass == C_LOAD);
                state_d = S_FETCH;
            end

            S_TRAP: begin
                illegal = 1'b1;
            end

            default: begin
                state_d = S_TRAP;
            end
        endcase

        if (rst) begin
            mem_req     = 1'b1;
            mem_we      = 1'b0;
            ir_we       = 1'b0;
            pc_we       = 1'b0;
            reg_we      = 1'b0;
            alu_src_imm = 1'b0;
            pc_src_br   = 1'b0;
            wb_sel      = 1'b0;
            illegal     = 1'b0;
        end
    end

`ifdef RETIRE_CNT_EN
    // Count retired instructions, one per PC update, wrapping naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (pc_we) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl.
// A driver issues directed and random instructions with random memory wait
// states and pushes a per-instruction expectation computed from the
// instruction rules; a monitor accumulates what the DUT does and compares at
// every retirement (pc_we) or trap entry. Define RETIRE_CNT_EN to also check
// the retire counter.
module tb_multicycle_ctrl;

    localparam int TRAP_HOLD = 20;
    localparam int N_RANDOM  = 150;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        mem_ready = 1'b0;
    logic        br_taken = 1'b0;
    logic        mem_req, mem_we, ir_we, pc_we, reg_we;
    logic        alu_src_imm, pc_src_br, wb_sel, illegal;
    logic [2:0]  state;
    logic        rst_q = 1'b0;
`ifdef RETIRE_CNT_EN
    logic [31:0] retire_cnt;
    logic [31:0] ret_model = '0;
`endif

    multicycle_ctrl dut (
        .clk(clk),
        .rst(rst),
        .instr(instr),
        .mem_ready(mem_ready),
        .br_taken(br_taken),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .ir_we(ir_we),
        .pc_we(pc_we),
        .reg_we(reg_we),
        .alu_src_imm(alu_src_imm),
        .pc_src_br(pc_src_br),
        .wb_sel(wb_sel),
        .state(state),
        .illegal(illegal)
`ifdef RETIRE_CNT_EN
        ,
        .retire_cnt(retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) rst_q <= rst;

    typedef struct {
        bit trap;
        int lat;
        int mreq;
        int memw;
        int regw;
        int aluimm;
        bit wbsel;
        bit pcsrc;
        int rstate;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int pushed = 0;
    int popped = 0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Instruction class from the opcode/funct3 rules: 0 LOAD, 1 STORE, 2 BRANCH, 3 OPIMM, 4 OP, 5 illegal.
    function automatic int classify(input logic [31:0] w);
        logic [2:0] f3;
        f3 = w[14:12];
        case (w[6:0])
            7'b0000011: return (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ? 5 : 0;
            7'b0100011: return 1;
            7'b1100011: return (f3 == 3'd2 || f3 == 3'd3) ? 5 : 2;
            7'b0010011: return 3;
            7'b0110011: return 4;
            default:    return 5;
        endcase
    endfunction

    function automatic exp_t model(input int k, input int f, input int m, input bit bt);
        exp_t e;
        bit   ldst;
        ldst     = (k == 0) || (k == 1);
        e.trap   = (k == 5);
        case (k)
            0:       e.lat = 5 + f + m;
            1:       e.lat = 4 + f + m;
            2:       e.lat = 3 + f;
            3, 4:    e.lat = 4 + f;
            default: e.lat = 3 + f;
        endcase
        e.mreq   = f + 1 + (ldst ? m + 1 : 0);
        e.memw   = (k == 1) ? m + 1 : 0;
        e.regw   = (k == 0 || k == 3 || k == 4) ? 1 : 0;
        e.aluimm = (k == 0 || k == 1 || k == 3) ? 1 : 0;
        e.wbsel  = (k == 0);
        e.pcsrc  = (k == 2) ? bt : 1'b0;
        e.rstate = (k == 5) ? 5 : (k == 2) ? 2 : (k == 1) ? 3 : 4;
        return e;
    endfunction

    function automatic logic rbit();
        return ($urandom_range(0, 1) != 0);
    endfunction

    task automatic step(input logic rdy, input logic [31:0] w, input logic bt, input logic r);
        mem_ready = rdy;
        instr     = w;
        br_taken  = bt;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction through its full cycle plan and queue what it should do.
    task automatic applyStimulus(input logic [31:0] w, input int f, input int m, input bit bt);
        int k;
        k = classify(w);
        sb.push_back(model(k, f, m, bt));
        pushed++;
        repeat (f) step(1'b0, $urandom, rbit(), 1'b0);
        step(1'b1, w, rbit(), 1'b0);
        step(rbit(), $urandom, rbit(), 1'b0);
        if (k == 5) begin
            repeat (TRAP_HOLD) step(rbit(), $urandom, rbit(), 1'b0);
            step(1'b0, $urandom, rbit(), 1'b1);
            return;
        end
        step(rbit(), $urandom, bt, 1'b0);
        if (k == 0 || k == 1) begin
            repeat (m) step(1'b0, $urandom, rbit(), 1'b0);
            step(1'b1, $urandom, rbit(), 1'b0);
        end
        if (k != 1 && k != 2) begin
            step(rbit(), $urandom, rbit(), 1'b0);
        end
    endtask

    // A STORE whose memory wait is cut short by reset: nothing may retire.
    task automatic applyAbort();
        step(1'b1, 32'h00112023, 1'b0, 1'b0);
        step(1'b0, $urandom, 1'b0, 1'b0);
        step(1'b0, $urandom, 1'b0, 1'b0);
        step(1'b0, $urandom, 1'b0, 1'b0);
        step(1'b0, $urandom, 1'b0, 1'b0);
        step(1'b0, $urandom, 1'b0, 1'b1);
    endtask

    task automatic genInstr(output logic [31:0] w);
        int         pick;
        logic [2:0] f3;
        w    = $urandom;
        pick = $urandom_range(0, 11);
        case (pick)
            0, 1: begin
                do f3 = 3'($urandom_range(0, 7)); while (f3 inside {3'd3, 3'd6, 3'd7});
                w[6:0] = 7'b0000011;
                w[14:12] = f3;
            end
            2, 3: w[6:0] = 7'b0100011;
            4, 5: begin
                do f3 = 3'($urandom_range(0, 7)); while (f3 inside {3'd2, 3'd3});
                w[6:0] = 7'b1100011;
                w[14:12] = f3;
            end
            6, 7: w[6:0] = 7'b0010011;
            8:    w[6:0] = 7'b0110011;
            9: begin
                w[6:0] = 7'b0000011;
                w[14:12] = (rbit()) ? 3'd3 : 3'd7;
            end
            10: begin
                w[6:0] = 7'b1100011;
                w[14:12] = (rbit()) ? 3'd2 : 3'd3;
            end
            default: begin
                do w[6:0] = 7'($urandom);
                while (w[6:0] inside {7'b0000011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b0110011});
            end
        endcase
    endtask

    int  o_cyc, o_mreq, o_memw, o_irw, o_regw, o_alu, trap_cyc;
    bit  o_wbsel, in_trap;

    function automatic void clearObs();
        o_cyc = 0; o_mreq = 0; o_memw = 0; o_irw = 0; o_regw = 0; o_alu = 0; o_wbsel = 1'b0;
    endfunction

    // Monitor: accumulate per-instruction behaviour and compare at each retirement or trap entry.
    initial begin
        exp_t e;
        clearObs();
        in_trap  = 1'b0;
        trap_cyc = 0;
        forever begin
            @(negedge clk);
            if (rst_q) checkOutput("post_reset_state", state, 0);
            if (rst) begin
                if (rst_q)
                    checkOutput("reset_outputs",
                        {mem_req, mem_we, ir_we, pc_we, reg_we, alu_src_imm, pc_src_br, wb_sel, illegal},
                        9'b100000000);
                else
                    checkOutput("reset_no_pc_we", pc_we, 0);
                if (in_trap) checkOutput("trap_hold_cycles", trap_cyc, TRAP_HOLD);
                in_trap = 1'b0;
                clearObs();
            end else if (in_trap) begin
                trap_cyc++;
                checkOutput("trap_outputs", {illegal, mem_req, mem_we, ir_we, pc_we, reg_we, state}, {6'b100000, 3'd5});
            end else begin
                o_cyc++;
                o_mreq += int'(mem_req);
                o_memw += int'(mem_we);
                o_irw  += int'(ir_we);
                o_regw += int'(reg_we);
                if (state == 3'd2 && alu_src_imm) o_alu++;
                if (reg_we) o_wbsel = wb_sel;
                if (pc_we || illegal) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_retire", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        popped++;
                        checkOutput("retire_kind", illegal, e.trap);
                        checkOutput("latency", o_cyc, e.lat);
                        checkOutput("mem_req_cycles", o_mreq, e.mreq);
                        checkOutput("mem_we_cycles", o_memw, e.memw);
                        checkOutput("ir_we_pulses", o_irw, 1);
                        checkOutput("reg_we_pulses", o_regw, e.regw);
                        checkOutput("alu_src_imm", o_alu, e.aluimm);
                        checkOutput("pc_src_br", pc_src_br, e.pcsrc);
                        checkOutput("retire_state", state, e.rstate);
                        if (e.regw != 0) checkOutput("wb_sel", o_wbsel, e.wbsel);
                    end
                    if (illegal) begin
                        in_trap  = 1'b1;
                        trap_cyc = 1;
                    end
                    clearObs();
                end
            end
`ifdef RETIRE_CNT_EN
            if (rst_q) ret_model = '0;
            checkOutput("retire_cnt", retire_cnt, ret_model);
            if (pc_we && !rst) ret_model = ret_model + 32'd1;
`endif
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "[TB] watchdog expired");
    end

    // Driver: directed scenarios first, then randomized traffic.
    initial begin
        logic [31:0] w;
        repeat (3) step(1'b0, '0, 1'b0, 1'b1);

        applyStimulus(32'h00500093, 0, 0, 1'b0);
        applyStimulus(32'h00012083, 0, 2, 1'b0);
        applyStimulus(32'h00208463, 0, 0, 1'b1);
        applyStimulus(32'h00208463, 1, 0, 1'b0);
        applyStimulus(32'h0000007F, 1, 0, 1'b0);
        applyStimulus(32'h00112023, 2, 1, 1'b0);
        applyAbort();
        applyStimulus(32'h00500093, 1, 0, 1'b0);

        for (int i = 0; i < N_RANDOM; i++) begin
            genInstr(w);
            applyStimulus(w, $urandom_range(0, 3), $urandom_range(0, 3), rbit());
        end

`ifdef RETIRE_CNT_EN
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(32'h002081B3, $urandom_range(0, 2), 0, 1'b0);
        end
        checkOutput("retire_cnt_ten", retire_cnt, 10);
        force dut.retire_cnt = 32'hFFFFFFFF;
        ret_model = 32'hFFFFFFFF;
        #1;
        release dut.retire_cnt;
        applyStimulus(32'h002081B3, 0, 0, 1'b0);
        checkOutput("retire_cnt_wrap", retire_cnt, 0);
`endif

        repeat (3) step(1'b0, $urandom, 1'b0, 1'b0);
        checkOutput("scoreboard_empty", sb.size(), 0);
        checkOutput("retired_count", popped, pushed);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
